// File: rtl/disp_src_pkg.sv
// Shared types and sizing helpers for the display-source selector.
package disp_src_pkg;

    typedef enum logic [1:0] {
        StShow  = 2'd0,
        StPend  = 2'd1,
        StBlank = 2'd2
    } disp_state_e;

    // Width of a channel index; never below one bit.
    function automatic int unsigned sel_w(input int unsigned nch);
        return (nch < 2) ? 1 : $clog2(nch);
    endfunction

    // Width able to hold the value n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/disp_src_sel_tick_downcnt.sv
// Tick-driven down counter: loadable, decrements on tick, saturates at zero.
module tick_downcnt #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_tick,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    // Load has priority over the tick decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_count = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/disp_src_sel.sv
// N-channel display-source selector with frame-synchronous switching and blanking.
// Optional auto-scan enabled by defining DISP_AUTOSCAN_EN (adds the auto_en port).
module disp_src_sel
    import disp_src_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned NCH         = 4,
    parameter int unsigned BLANK_TICKS = 2,
    parameter int unsigned SCAN_TICKS  = 500,
    parameter int unsigned SELW        = sel_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] ch_data,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [SELW-1:0]  sel,
    input  logic             sel_load,
    input  logic             tick,
`ifdef DISP_AUTOSCAN_EN
    input  logic             auto_en,
`endif
    output logic [W-1:0]     d_out,
    output logic             d_valid,
    output logic [SELW-1:0]  cur_sel,
    output logic             blank
);

    localparam int unsigned BCW = cnt_w(BLANK_TICKS);
    localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

    disp_state_e     r_state, w_state_nxt;
    logic [SELW-1:0] r_pend, w_pend_nxt;
    logic [SELW-1:0] r_cur_sel, w_cur_nxt;
    logic [W-1:0]    r_d_out, w_d_nxt;
    logic            r_d_valid, w_v_nxt;
    logic            r_blank, w_blank_nxt;

    logic            w_ld_ok;
    logic [W-1:0]    w_cur_data;
    logic            w_cur_valid;
    logic            w_blank_load;
    logic            w_blank_last;
    logic [BCW-1:0]  w_blank_cnt;
    logic            w_blank_zero;

    assign w_ld_ok = sel_load && ({1'b0, sel} < NCH_L);

    // Mux out the currently selected channel.
    always_comb begin
        w_cur_data  = '0;
        w_cur_valid = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (SELW'(i) == r_cur_sel) begin
                w_cur_data  = ch_data[i*W +: W];
                w_cur_valid = ch_valid[i];
            end
        end
    end

    tick_downcnt #(
        .CW (BCW)
    ) u_blank_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_blank_load),
        .i_load_val (BCW'(BLANK_TICKS)),
        .i_tick     (tick && (r_state == StBlank)),
        .o_count    (w_blank_cnt),
        .o_zero     (w_blank_zero)
    );

    // The tick that brings the counter to zero ends blanking.
    assign w_blank_last = w_blank_zero || (w_blank_cnt == BCW'(1));

`ifdef DISP_AUTOSCAN_EN
    localparam int unsigned SCW = cnt_w(SCAN_TICKS);

    logic            w_scan_load;
    logic [SCW-1:0]  w_scan_val;
    logic            w_scan_dec;
    logic            w_scan_req;
    logic [SELW-1:0] w_scan_sel;
    logic [SCW-1:0]  w_scan_cnt;
    logic            w_scan_zero;

    // Counter holds ticks remaining; zero means cleared (no tick counted yet).
    always_comb begin
        w_scan_load = 1'b1;
        w_scan_val  = '0;
        w_scan_dec  = 1'b0;
        w_scan_req  = 1'b0;
        if ((r_state == StShow) && auto_en && !sel_load) begin
            w_scan_load = 1'b0;
            if (tick) begin
                if (w_scan_zero) begin
                    w_scan_load = 1'b1;
                    if (SCAN_TICKS <= 1) begin
                        w_scan_req = 1'b1;
                    end else begin
                        w_scan_val = SCW'(SCAN_TICKS - 1);
                    end
                end else if (w_scan_cnt == SCW'(1)) begin
                    w_scan_req  = 1'b1;
                    w_scan_load = 1'b1;
                end else begin
                    w_scan_dec = 1'b1;
                end
            end
        end
    end

    assign w_scan_sel = (r_cur_sel == SELW'(NCH - 1)) ? '0 : r_cur_sel + SELW'(1);

    tick_downcnt #(
        .CW (SCW)
    ) u_scan_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_scan_load),
        .i_load_val (w_scan_val),
        .i_tick     (w_scan_dec),
        .o_count    (w_scan_cnt),
        .o_zero     (w_scan_zero)
    );
`endif

    // Next-state and output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_cur_nxt    = r_cur_sel;
        w_d_nxt      = r_d_out;
        w_v_nxt      = r_d_valid;
        w_blank_nxt  = r_blank;
        w_blank_load = 1'b0;
        case (r_state)
            StShow, StPend: begin
                if (w_cur_valid) begin
                    w_d_nxt = w_cur_data;
                end
                w_v_nxt = w_cur_valid;
                if (w_ld_ok) begin
                    // A load in the same cycle as a tick leaves that tick unused.
                    w_pend_nxt  = sel;
                    w_state_nxt = (sel == r_cur_sel) ? StShow : StPend;
                end else if ((r_state == StPend) && tick) begin
                    w_cur_nxt = r_pend;
                    w_d_nxt   = '0;
                    w_v_nxt   = 1'b0;
                    if (BLANK_TICKS == 0) begin
                        w_state_nxt = StShow;
                    end else begin
                        w_state_nxt  = StBlank;
                        w_blank_nxt  = 1'b1;
                        w_blank_load = 1'b1;
                    end
                end
`ifdef DISP_AUTOSCAN_EN
                else if ((r_state == StShow) && w_scan_req) begin
                    w_pend_nxt  = w_scan_sel;
                    w_state_nxt = StPend;
                end
`endif
            end
            StBlank: begin
                if (w_ld_ok) begin
                    w_pend_nxt = sel;
                end
                if (tick && w_blank_last) begin
                    w_blank_nxt = 1'b0;
                    w_state_nxt = (w_pend_nxt != r_cur_sel) ? StPend : StShow;
                end
            end
            default: begin
                w_state_nxt = StShow;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StShow;
            r_pend    <= '0;
            r_cur_sel <= '0;
            r_d_out   <= '0;
            r_d_valid <= 1'b0;
            r_blank   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_cur_sel <= w_cur_nxt;
            r_d_out   <= w_d_nxt;
            r_d_valid <= w_v_nxt;
            r_blank   <= w_blank_nxt;
        end
    end

    assign d_out   = r_d_out;
    assign d_valid = r_d_valid;
    assign cur_sel = r_cur_sel;
    assign blank   = r_blank;

endmodule

// File: tb/tb_disp_src_sel.sv
// Testbench for disp_src_sel: directed table, corner sequences, random vs. reference model.
module tb_disp_src_sel;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int BT  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH*W-1:0] ch_data  = '0;
    logic [NCH-1:0]   ch_valid = '0;
    logic [1:0]       sel      = '0;
    logic             sel_load = 1'b0;
    logic             tick     = 1'b0;
    logic [W-1:0]     d_out;
    logic             d_valid;
    logic [1:0]       cur_sel;
    logic             blank;

    logic [3*W-1:0]   ch_data3  = {16'h3333, 16'h2222, 16'h1111};
    logic [2:0]       ch_valid3 = 3'b111;
    logic [1:0]       sel3 = '0;
    logic             ld3  = 1'b0;
    logic             tk3  = 1'b0;
    logic [W-1:0]     d_out3;
    logic             d_valid3;
    logic [1:0]       cur_sel3;
    logic             blank3;
`ifdef DISP_AUTOSCAN_EN
    logic             auto_en  = 1'b0;
    logic             auto_en3 = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    disp_src_sel #(
        .W (W), .NCH (NCH), .BLANK_TICKS (BT), .SCAN_TICKS (3)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .sel      (sel),
        .sel_load (sel_load),
        .tick     (tick),
`ifdef DISP_AUTOSCAN_EN
        .auto_en  (auto_en),
`endif
        .d_out    (d_out),
        .d_valid  (d_valid),
        .cur_sel  (cur_sel),
        .blank    (blank)
    );

    disp_src_sel #(
        .W (W), .NCH (3), .BLANK_TICKS (BT), .SCAN_TICKS (3)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .ch_data  (ch_data3),
        .ch_valid (ch_valid3),
        .sel      (sel3),
        .sel_load (ld3),
        .tick     (tk3),
`ifdef DISP_AUTOSCAN_EN
        .auto_en  (auto_en3),
`endif
        .d_out    (d_out3),
        .d_valid  (d_valid3),
        .cur_sel  (cur_sel3),
        .blank    (blank3)
    );

    typedef struct {
        logic [3:0]  v;
        logic [1:0]  s;
        logic        l;
        logic        t;
        logic [15:0] ed;
        logic        ev;
        logic [1:0]  ec;
        logic        eb;
    } vec_t;

    vec_t tbl[18];

    // Reference model: display position expressed as plain counters and flags.
    int         m_cur, m_pend, m_left;
    bit         m_req, m_v, m_blank;
    logic [W-1:0] m_d;

    task automatic model_reset();
        m_cur = 0; m_pend = 0; m_left = 0;
        m_req = 0; m_v = 0; m_blank = 0; m_d = '0;
    endtask

    task automatic model_step(input logic [NCH*W-1:0] data, input logic [NCH-1:0] v,
                              input int s, input bit l, input bit t);
        bit           ok = l && (s < NCH);
        logic [W-1:0] cd = data[m_cur*W +: W];
        if (m_left > 0) begin
            if (ok) m_pend = s;
            if (t) begin
                m_left--;
                if (m_left == 0) begin
                    m_blank = 0;
                    m_req   = (m_pend != m_cur);
                end
            end
        end else begin
            if (v[m_cur]) m_d = cd;
            m_v = v[m_cur];
            if (ok) begin
                m_req  = (s != m_cur);
                m_pend = s;
            end else if (t && m_req) begin
                m_cur   = m_pend;
                m_req   = 0;
                m_d     = '0;
                m_v     = 0;
                m_left  = BT;
                m_blank = (BT > 0);
            end
        end
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [1:0] s, input logic l, input logic t);
        ch_valid = v; sel = s; sel_load = l; tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc3(input logic [1:0] s, input logic l, input logic t);
        sel3 = s; ld3 = l; tk3 = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v     s  l  t   d         v  cur b
        tbl[0]  = '{4'hF, 0, 0, 0, 16'h1234, 1, 0, 0};
        tbl[1]  = '{4'hE, 0, 0, 0, 16'h1234, 0, 0, 0};
        tbl[2]  = '{4'hF, 2, 1, 0, 16'h1234, 1, 0, 0};
        tbl[3]  = '{4'hF, 0, 0, 0, 16'h1234, 1, 0, 0};
        tbl[4]  = '{4'hF, 0, 0, 1, 16'h0000, 0, 2, 1};
        tbl[5]  = '{4'hF, 0, 0, 0, 16'h0000, 0, 2, 1};
        tbl[6]  = '{4'hF, 0, 0, 1, 16'h0000, 0, 2, 1};
        tbl[7]  = '{4'hF, 0, 0, 1, 16'h0000, 0, 2, 0};
        tbl[8]  = '{4'hF, 0, 0, 0, 16'h5678, 1, 2, 0};
        tbl[9]  = '{4'hF, 2, 1, 0, 16'h5678, 1, 2, 0};
        tbl[10] = '{4'hF, 0, 0, 1, 16'h5678, 1, 2, 0};
        tbl[11] = '{4'hF, 1, 1, 1, 16'h5678, 1, 2, 0};
        tbl[12] = '{4'hF, 0, 0, 1, 16'h0000, 0, 1, 1};
        tbl[13] = '{4'hF, 3, 1, 0, 16'h0000, 0, 1, 1};
        tbl[14] = '{4'hF, 0, 0, 1, 16'h0000, 0, 1, 1};
        tbl[15] = '{4'hF, 0, 0, 1, 16'h0000, 0, 1, 0};
        tbl[16] = '{4'hF, 0, 0, 0, 16'hAAAA, 1, 1, 0};
        tbl[17] = '{4'hF, 0, 0, 1, 16'h0000, 0, 3, 1};

        // Reset values while reset is held.
        #2;
        check("reset_vals", {d_out, d_valid, cur_sel, blank}, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Out-of-range selection on a 3-channel instance, then load+tick collision.
        cyc3(2'd3, 1'b1, 1'b0);
        check("inv_sel", {18'h0, cur_sel3, blank3} >> 0, {18'h0, 2'd0, 1'b0});
        cyc3(2'd0, 1'b0, 1'b1);
        check("inv_tick", {17'h0, cur_sel3, blank3}, {17'h0, 2'd0, 1'b0});
        cyc3(2'd1, 1'b1, 1'b1);
        check("ld_tick_same", {17'h0, cur_sel3, blank3}, {17'h0, 2'd0, 1'b0});
        cyc3(2'd0, 1'b0, 1'b1);
        check("ld_tick_next", {17'h0, cur_sel3, blank3}, {17'h0, 2'd1, 1'b1});
        cyc3(2'd0, 1'b0, 1'b0);

        // Directed table on the 4-channel instance.
        ch_data = {16'hBEEF, 16'h5678, 16'hAAAA, 16'h1234};
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].t);
            check($sformatf("tbl%0d", i), {d_out, d_valid, cur_sel, blank},
                  {tbl[i].ed, tbl[i].ev, tbl[i].ec, tbl[i].eb});
        end

        // Asynchronous reset in the middle of blanking, with no clock edge in between.
        ch_valid = '0; tick = 1'b0; sel_load = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {d_out, d_valid, cur_sel, blank}, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'h0, 2'd0, 1'b0, 1'b1);
        check("rst_discard", {d_out, d_valid, cur_sel, blank}, 20'h0);

        // Random stimulus against the reference model.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] rv;
            logic [1:0] rs;
            logic       rl, rt;
            ch_data = {$urandom(), $urandom()};
            rv = 4'($urandom());
            rs = 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 2) == 0);
            model_step(ch_data, rv, int'(rs), rl, rt);
            cyc(rv, rs, rl, rt);
            check("rand", {d_out, d_valid, cur_sel, blank}, {m_d, m_v, 2'(m_cur), m_blank});
        end

`ifdef DISP_AUTOSCAN_EN
        // Auto-scan wrap from the last channel back to channel 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'hF, 2'd3, 1'b1, 1'b0);
        cyc(4'hF, 2'd0, 1'b0, 1'b1);
        cyc(4'hF, 2'd0, 1'b0, 1'b1);
        cyc(4'hF, 2'd0, 1'b0, 1'b1);
        auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(4'hF, 2'd0, 1'b0, 1'b1);
            cyc(4'hF, 2'd0, 1'b0, 1'b0);
        end
        check("scan_pend", {17'h0, cur_sel, blank}, {17'h0, 2'd3, 1'b0});
        cyc(4'hF, 2'd0, 1'b0, 1'b1);
        check("scan_wrap", {17'h0, cur_sel, blank}, {17'h0, 2'd0, 1'b1});
        auto_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
